// File: rtl/sync_tdp_ram_be.sv
// True-dual-port synchronous RAM with byte enables, per-port read-during-write mode,
// configurable output pipeline with valid strobes, collision flag and optional zero-fill.
module sync_tdp_ram_be #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned RDW_MODE_A = 0,
  parameter int unsigned RDW_MODE_B = 0,
  parameter int unsigned INIT_ZERO  = 0
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RI,
  output logic                    Ready_SO,
  input  logic                    CSelA_SI,
  input  logic                    WrEnA_SI,
  input  logic [DATA_WIDTH/8-1:0] BeA_SI,
  input  logic [DATA_WIDTH-1:0]   WrDataA_DI,
  input  logic [ADDR_WIDTH-1:0]   AddrA_DI,
  output logic [DATA_WIDTH-1:0]   RdDataA_DO,
  output logic                    RdValidA_SO,
  input  logic                    CSelB_SI,
  input  logic                    WrEnB_SI,
  input  logic [DATA_WIDTH/8-1:0] BeB_SI,
  input  logic [DATA_WIDTH-1:0]   WrDataB_DI,
  input  logic [ADDR_WIDTH-1:0]   AddrB_DI,
  output logic [DATA_WIDTH-1:0]   RdDataB_DO,
  output logic                    RdValidB_SO,
  output logic                    CollErr_SO
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  if (DATA_WIDTH % 8 != 0) begin : g_chk_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (DATA_DEPTH > 2**ADDR_WIDTH) begin : g_chk_depth
    $error("DATA_DEPTH exceeds 2**ADDR_WIDTH");
  end
  if (OUT_REGS > 4) begin : g_chk_oregs
    $error("OUT_REGS must be 0..4");
  end
  if (RDW_MODE_A > 2 || RDW_MODE_B > 2) begin : g_chk_rdw
    $error("RDW_MODE_* must be 0..2");
  end

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   fill_q, fill_d;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  cs     [2];
  logic                  we     [2];
  logic [NB-1:0]         be     [2];
  logic [DATA_WIDTH-1:0] wd     [2];
  logic [ADDR_WIDTH-1:0] ad     [2];
  logic                  acc    [2];
  logic                  wacc   [2];
  logic                  inr    [2];
  logic [IW-1:0]         idx    [2];
  logic [DATA_WIDTH-1:0] rword  [2];
  logic [DATA_WIDTH-1:0] merged [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_vld  [2];
  logic                  coll_q;

  assign cs[0] = CSelA_SI;   assign cs[1] = CSelB_SI;
  assign we[0] = WrEnA_SI;   assign we[1] = WrEnB_SI;
  assign be[0] = BeA_SI;     assign be[1] = BeB_SI;
  assign wd[0] = WrDataA_DI; assign wd[1] = WrDataB_DI;
  assign ad[0] = AddrA_DI;   assign ad[1] = AddrB_DI;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        fill_d  = '0;
        state_d = (INIT_ZERO != 0) ? FILL : RUN;
      end
      FILL: begin
        if (fill_q == IW'(DATA_DEPTH - 1)) state_d = RUN;
        else                               fill_d  = fill_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  assign Ready_SO = (state_q == RUN);

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      acc[p]  = Ready_SO & cs[p];
      wacc[p] = acc[p] & we[p];
      inr[p]  = ({1'b0, ad[p]} < (ADDR_WIDTH + 1)'(DATA_DEPTH));
      idx[p]  = ad[p][IW-1:0];
      rword[p] = inr[p] ? mem[idx[p]] : 'x;
      merged[p] = rword[p];
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[p][b]) merged[p][8*b +: 8] = wd[p][8*b +: 8];
      end
    end
  end

  // B bytes are scheduled first so A's later non-blocking update wins on overlap.
  always_ff @(posedge Clk_CI) begin
    if (state_q == FILL) mem[fill_q] <= '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wacc[1] && inr[1] && be[1][b]) mem[idx[1]][8*b +: 8] <= wd[1][8*b +: 8];
      if (wacc[0] && inr[0] && be[0][b]) mem[idx[0]][8*b +: 8] <= wd[0][8*b +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int unsigned MODE = (p == 0) ? RDW_MODE_A : RDW_MODE_B;
    logic [DATA_WIDTH-1:0] data_q [OUT_REGS+1];
    logic [OUT_REGS:0]     vld_q;

    // Data registers only load on a valid slot, so the output holds between reads.
    always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
        vld_q <= '0;
        for (int unsigned i = 0; i <= OUT_REGS; i++) data_q[i] <= '0;
      end else begin
        vld_q[0] <= 1'b0;
        if (acc[p]) begin
          if (!we[p] || MODE == 0) begin
            data_q[0] <= rword[p];
            vld_q[0]  <= 1'b1;
          end else if (MODE == 1) begin
            data_q[0] <= merged[p];
            vld_q[0]  <= 1'b1;
          end
        end
        for (int unsigned i = 1; i <= OUT_REGS; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign rd_data[p] = data_q[OUT_REGS];
    assign rd_vld[p]  = vld_q[OUT_REGS];
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) coll_q <= 1'b0;
    else        coll_q <= wacc[0] & wacc[1] & (ad[0] == ad[1]);
  end

  assign RdDataA_DO  = rd_data[0];
  assign RdValidA_SO = rd_vld[0];
  assign RdDataB_DO  = rd_data[1];
  assign RdValidB_SO = rd_vld[1];
  assign CollErr_SO  = coll_q;

  a_range_a: assert property (@(posedge Clk_CI) disable iff (Rst_RI) acc[0] |-> inr[0]);
  a_range_b: assert property (@(posedge Clk_CI) disable iff (Rst_RI) acc[1] |-> inr[1]);

endmodule

// File: tb/tb_sync_tdp_ram_be.sv
// Bench for sync_tdp_ram_be: two shared-input instances (fill + 2-stage pipeline, and
// no-fill + direct output) checked every cycle against a word-level reference model.
module tb_sync_tdp_ram_be;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic csA, weA, csB, weB;
  logic [3:0] beA, beB, adA, adB;
  logic [31:0] wdA, wdB;

  logic rdy0, rdy1, coll0, coll1, rvA0, rvB0, rvA1, rvB1;
  logic [31:0] rdA0, rdB0, rdA1, rdB1;

  int unsigned ntest = 0;
  int unsigned nfail = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  sync_tdp_ram_be #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_REGS(2),
                    .RDW_MODE_A(0), .RDW_MODE_B(1), .INIT_ZERO(1)) u_dut0 (
    .Clk_CI(clk), .Rst_RI(rst), .Ready_SO(rdy0),
    .CSelA_SI(csA), .WrEnA_SI(weA), .BeA_SI(beA), .WrDataA_DI(wdA), .AddrA_DI(adA),
    .RdDataA_DO(rdA0), .RdValidA_SO(rvA0),
    .CSelB_SI(csB), .WrEnB_SI(weB), .BeB_SI(beB), .WrDataB_DI(wdB), .AddrB_DI(adB),
    .RdDataB_DO(rdB0), .RdValidB_SO(rvB0), .CollErr_SO(coll0));

  sync_tdp_ram_be #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_REGS(0),
                    .RDW_MODE_A(2), .RDW_MODE_B(0), .INIT_ZERO(0)) u_dut1 (
    .Clk_CI(clk), .Rst_RI(rst), .Ready_SO(rdy1),
    .CSelA_SI(csA), .WrEnA_SI(weA), .BeA_SI(beA), .WrDataA_DI(wdA), .AddrA_DI(adA),
    .RdDataA_DO(rdA1), .RdValidA_SO(rvA1),
    .CSelB_SI(csB), .WrEnB_SI(weB), .BeB_SI(beB), .WrDataB_DI(wdB), .AddrB_DI(adB),
    .RdDataB_DO(rdB1), .RdValidB_SO(rvB1), .CollErr_SO(coll1));

  // Per-instance configuration: output latency beyond the first cycle, RDW mode, ready point.
  function automatic int unsigned oregs_of(input int unsigned d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic int unsigned mode_of(input int unsigned d, input int unsigned p);
    if (d == 0) return (p == 0) ? 0 : 1;
    return (p == 0) ? 2 : 0;
  endfunction
  function automatic int unsigned ready_at(input int unsigned d);
    return (d == 0) ? DEPTH + 1 : 1;
  endfunction
  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    bit          known;
  } ent_t;

  logic [31:0] mem_m   [2][16];
  bit          known_m [2][16];
  int unsigned cnt_m   [2];
  bit          coll_m  [2];
  ent_t        q_m     [4][$];
  logic [31:0] held_m  [4];
  bit          hk_m    [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic        cs_ [2];
    logic        we_ [2];
    logic [3:0]  be_ [2];
    logic [3:0]  ad_ [2];
    logic [31:0] wd_ [2];
    bit          ac_ [2];
    logic [31:0] old [16];
    bit          ok  [16];
    ent_t        e;
    cs_[0] = csA; we_[0] = weA; be_[0] = beA; ad_[0] = adA; wd_[0] = wdA;
    cs_[1] = csB; we_[1] = weB; be_[1] = beB; ad_[1] = adB; wd_[1] = wdB;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cnt_m[d] = 0;
        coll_m[d] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          q_m[2*d+p].delete();
          held_m[2*d+p] = '0;
          hk_m[2*d+p] = 1'b1;
        end
      end else begin
        old = mem_m[d];
        ok  = known_m[d];
        for (int p = 0; p < 2; p++) begin
          ac_[p] = (cnt_m[d] >= ready_at(d)) && cs_[p];
          e.due = cyc + oregs_of(d);
          if (ac_[p] && (!we_[p] || mode_of(d, p) == 0)) begin
            e.data = old[ad_[p]]; e.known = ok[ad_[p]];
            q_m[2*d+p].push_back(e);
          end else if (ac_[p] && mode_of(d, p) == 1) begin
            e.data = bmerge(old[ad_[p]], wd_[p], be_[p]);
            e.known = ok[ad_[p]] || (be_[p] == 4'hF);
            q_m[2*d+p].push_back(e);
          end
        end
        for (int i = 0; i < 2; i++) begin
          int p;
          p = 1 - i;
          if (ac_[p] && we_[p]) begin
            mem_m[d][ad_[p]] = bmerge(mem_m[d][ad_[p]], wd_[p], be_[p]);
            if (be_[p] == 4'hF) known_m[d][ad_[p]] = 1'b1;
          end
        end
        coll_m[d] = ac_[0] && we_[0] && ac_[1] && we_[1] && (ad_[0] == ad_[1]);
        if (cnt_m[d] < ready_at(d)) begin
          cnt_m[d]++;
          if (ready_at(d) > 1 && cnt_m[d] == ready_at(d)) begin
            for (int a = 0; a < 16; a++) begin
              mem_m[d][a] = '0;
              known_m[d][a] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] rd [4];
    logic        rv [4];
    logic        ry [2];
    logic        co [2];
    ent_t        e;
    rd[0] = rdA0; rd[1] = rdB0; rd[2] = rdA1; rd[3] = rdB1;
    rv[0] = rvA0; rv[1] = rvB0; rv[2] = rvA1; rv[3] = rvB1;
    ry[0] = rdy0; ry[1] = rdy1; co[0] = coll0; co[1] = coll1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d.ready", d), 32'(ry[d]), 32'(cnt_m[d] >= ready_at(d)));
      chk($sformatf("d%0d.collerr", d), 32'(co[d]), 32'(coll_m[d]));
      for (int p = 0; p < 2; p++) begin
        int k;
        k = 2*d + p;
        if (q_m[k].size() > 0 && q_m[k][0].due == cyc) begin
          e = q_m[k].pop_front();
          chk($sformatf("d%0d.p%0d.valid", d, p), 32'(rv[k]), 32'd1);
          if (e.known) chk($sformatf("d%0d.p%0d.data", d, p), rd[k], e.data);
          held_m[k] = e.data;
          hk_m[k] = e.known;
        end else begin
          chk($sformatf("d%0d.p%0d.valid", d, p), 32'(rv[k]), 32'd0);
          if (hk_m[k]) chk($sformatf("d%0d.p%0d.hold", d, p), rd[k], held_m[k]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic setA(input logic cs, input logic we, input logic [3:0] be,
                      input logic [3:0] ad, input logic [31:0] wd);
    csA = cs; weA = we; beA = be; adA = ad; wdA = wd;
  endtask
  task automatic setB(input logic cs, input logic we, input logic [3:0] be,
                      input logic [3:0] ad, input logic [31:0] wd);
    csB = cs; weB = we; beB = be; adB = ad; wdB = wd;
  endtask
  task automatic idle();
    setA(1'b0, 1'b0, 4'h0, 4'h0, '0);
    setB(1'b0, 1'b0, 4'h0, 4'h0, '0);
  endtask

  task automatic count_fill(input string tag);
    int unsigned n;
    bit hit;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (rdy0) hit = 1'b1;
      else      n++;
    end
    chk(tag, n, DEPTH);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) begin
        mem_m[d][a] = '0;
        known_m[d][a] = 1'b0;
      end
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    count_fill("fill_len");

    // Reset in the middle of a fill restarts it from word 0.
    rst = 1'b1; step(); rst = 1'b0;
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    count_fill("refill_len");

    for (int a = 0; a < 16; a++) begin
      setA(1'b1, 1'b0, 4'h0, 4'(a), '0);
      step();
    end
    idle(); repeat (3) step();

    for (int a = 0; a < 16; a++) begin
      setA(1'b1, 1'b1, 4'hF, 4'(a), $urandom);
      step();
    end
    idle(); step();

    setA(1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF); step();
    setA(1'b1, 1'b0, 4'h0, 4'd5, '0); step();
    idle(); step(); step();
    chk("oregs_valid", 32'(rvA0), 32'd1);
    chk("oregs_data", rdA0, 32'hDEADBEEF);

    setA(1'b1, 1'b1, 4'hF, 4'd3, 32'h11223344); step();
    setA(1'b1, 1'b1, 4'b0101, 4'd3, 32'hAABBCCDD); step();
    setA(1'b1, 1'b0, 4'h0, 4'd3, '0); step();
    idle(); step(); step();
    chk("byte_en", rdA0, 32'h11BB33DD);

    setA(1'b1, 1'b1, 4'hF, 4'd9, 32'h1); step();
    setA(1'b1, 1'b1, 4'hF, 4'd9, 32'h2); step();
    chk("no_change_valid", 32'(rvA1), 32'd0);
    idle();
    setB(1'b1, 1'b1, 4'hF, 4'd9, 32'h3); step();
    chk("read_first_b", rdB1, 32'h2);
    idle(); step();
    chk("read_first_a", rdA0, 32'h1);
    step();
    chk("write_first_b", rdB0, 32'h3);
    step();

    setA(1'b1, 1'b1, 4'b0011, 4'd4, 32'hAAAAAAAA);
    setB(1'b1, 1'b1, 4'b1111, 4'd4, 32'hBBBBBBBB);
    step();
    chk("coll_pulse", 32'(coll0), 32'd1);
    idle(); step();
    chk("coll_clear", 32'(coll0), 32'd0);
    setA(1'b1, 1'b0, 4'h0, 4'd4, '0); step();
    idle(); step(); step();
    chk("coll_merge", rdA0, 32'hBBBBAAAA);
    setA(1'b1, 1'b1, 4'hF, 4'd4, 32'h12345678);
    setB(1'b1, 1'b0, 4'h0, 4'd4, '0);
    step();
    chk("cross_old", rdB1, 32'hBBBBAAAA);
    idle(); repeat (3) step();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      setA($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
           4'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15)),
           $urandom);
      setB($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
           4'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15)),
           $urandom);
      step();
    end
    rst = 1'b0;
    idle(); repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
